// File: rtl/core_pkg.sv
// Shared decode definitions: op classes, instruction formats, fixed exuType codes and the
// decoded-op packet that travels from decode to issue.
package core_pkg;

  localparam logic [2:0] OpMem    = 3'd0;
  localparam logic [2:0] OpAlu    = 3'd1;
  localparam logic [2:0] OpBru    = 3'd2;
  localparam logic [2:0] OpSystem = 3'd3;
  localparam logic [2:0] OpFence  = 3'd4;
  localparam logic [2:0] OpMu     = 3'd5;

  localparam logic [3:0] TypeN   = 4'd0;
  localparam logic [3:0] TypeU   = 4'd1;
  localparam logic [3:0] TypeJ   = 4'd2;
  localparam logic [3:0] TypeS   = 4'd3;
  localparam logic [3:0] TypeIr  = 4'd4;
  localparam logic [3:0] TypeCsr = 4'd5;
  localparam logic [3:0] TypeR   = 4'd6;
  localparam logic [3:0] TypeB   = 4'd7;
  localparam logic [3:0] TypeI   = 4'd8;

  localparam logic [6:0] ExuLui   = 7'h00;
  localparam logic [6:0] ExuAuipc = 7'h40;
  localparam logic [6:0] ExuJal   = 7'h4E;
  localparam logic [6:0] ExuJalr  = 7'h4A;

  typedef struct packed {
    logic [2:0]  op_type;
    logic [6:0]  exu_type;
    logic [31:0] imm;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  dest_addr;
    logic        dest_is_reg;
    logic        illegal;
  } dec_op_t;

  // inst[6:2] values this core implements (no W-suffixed RV64 ops).
  function automatic logic is_rv64im_opcode(input logic [4:0] opc);
    case (opc)
      5'b00000, 5'b01000, 5'b00100, 5'b01100, 5'b01101, 5'b00101,
      5'b11000, 5'b11011, 5'b11001, 5'b00011, 5'b11100: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/decode_comb.sv
// Purely combinational RV64IM decoder: instruction word to op class, exuType, immediate,
// register selects and illegal flag.
module decode_comb
  import core_pkg::*;
(
  input  logic [31:0] inst_i,
  output dec_op_t     dec_o,
  output logic        use_rs1_o,
  output logic        use_rs2_o
);

  logic [2:0]  fun3;
  logic [2:0]  fun_op;
  logic [4:0]  base;
  logic        illegal;
  logic [3:0]  itype;
  logic [2:0]  op;
  logic [6:0]  exu;
  logic [31:0] imm;

  always_comb begin
    fun3    = inst_i[14:12];
    fun_op  = {inst_i[6], inst_i[4], inst_i[2]};
    base    = {fun3, inst_i[5], inst_i[3]};
    illegal = (inst_i[1:0] != 2'b11) || (fun_op == 3'b111) ||
              !is_rv64im_opcode(inst_i[6:2]);
    itype   = TypeN;
    op      = OpSystem;
    exu     = '0;
    if (!illegal) begin
      case (fun_op)
        3'b010: begin
          if (inst_i[5]) begin
            itype = TypeR;
            op    = inst_i[25] ? OpMu : OpAlu;
            exu   = {1'b0, inst_i[30], base};
          end else if (fun3[1:0] == 2'b01) begin
            itype = TypeIr;
            op    = OpAlu;
            exu   = {1'b0, inst_i[30], base};
          end else begin
            itype = TypeI;
            op    = OpAlu;
            exu   = {2'b00, base};
          end
        end
        3'b011: begin
          itype = TypeU;
          op    = OpAlu;
          exu   = inst_i[5] ? ExuLui : ExuAuipc;
        end
        3'b100: begin
          itype = TypeB;
          op    = OpBru;
          exu   = {2'b01, base};
        end
        3'b101: begin
          itype = inst_i[3] ? TypeJ : TypeI;
          op    = OpBru;
          exu   = inst_i[3] ? ExuJal : ExuJalr;
        end
        3'b000: begin
          itype = inst_i[5] ? TypeS : TypeI;
          op    = OpMem;
          exu   = {2'b00, base};
        end
        3'b001: begin
          itype = TypeN;
          op    = OpFence;
          exu   = {2'b10, base};
        end
        3'b110: begin
          op = OpSystem;
          if (fun3 == 3'b000) begin
            itype = TypeN;
            exu   = {inst_i[21:20], base};
          end else begin
            itype = fun3[2] ? TypeCsr : TypeI;
            exu   = {2'b00, base};
          end
        end
        default: ;
      endcase
    end

    case (itype)
      TypeI:   imm = {{20{inst_i[31]}}, inst_i[31:20]};
      TypeS:   imm = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      TypeB:   imm = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8],
                      1'b0};
      TypeJ:   imm = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21],
                      1'b0};
      TypeU:   imm = {inst_i[31:12], 12'h000};
      TypeCsr: imm = {27'b0, inst_i[19:15]};
      TypeIr:  imm = {26'b0, inst_i[25:20]};
      default: imm = '0;
    endcase

    use_rs1_o = itype inside {TypeI, TypeIr, TypeS, TypeB, TypeR};
    use_rs2_o = itype inside {TypeS, TypeB, TypeR};

    dec_o.op_type     = op;
    dec_o.exu_type    = exu;
    dec_o.imm         = imm;
    dec_o.rs1_addr    = use_rs1_o ? inst_i[19:15] : 5'd0;
    dec_o.rs2_addr    = use_rs2_o ? inst_i[24:20] : 5'd0;
    dec_o.dest_addr   = inst_i[11:7];
    // TypeN covers fence, privileged system and illegal encodings.
    dec_o.dest_is_reg = !(itype inside {TypeN, TypeS, TypeB});
    dec_o.illegal     = illegal;
  end

endmodule

// File: rtl/decode_buf.sv
// Decode stage with a DEPTH-entry circular queue of decoded ops; operands are sampled in the
// accept cycle so issue stalls never hold fetch combinationally.
module decode_buf
  import core_pkg::*;
#(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CNTW  = $clog2(DEPTH) + 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  input  logic            in_is_pre,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2:0]      out_opType,
  output logic [6:0]      out_exuType,
  output logic [31:0]     out_imm,
  output logic [4:0]      out_rs1_addr,
  output logic [4:0]      out_rs2_addr,
  output logic [4:0]      out_dest_addr,
  output logic [XLEN-1:0] out_rs1_data,
  output logic [XLEN-1:0] out_rs2_data,
  output logic [XLEN-1:0] out_csr_data,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_inst,
  output logic [11:0]     out_csr_addr,
  output logic            out_dest_is_reg,
  output logic            out_is_pre,
  output logic            out_illegal,
  output logic [CNTW-1:0] count,
  input  logic            flush
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  typedef struct packed {
    dec_op_t         dec;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] csr_data;
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic            is_pre;
  } entry_t;

  entry_t          ent_q [DEPTH];
  entry_t          ent_d [DEPTH];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNTW-1:0] count_q, count_d;

  dec_op_t dec;
  logic    use_rs1, use_rs2;
  entry_t  new_ent, head;
  logic    push, pop;

  decode_comb u_decode_comb (
    .inst_i    (in_inst),
    .dec_o     (dec),
    .use_rs1_o (use_rs1),
    .use_rs2_o (use_rs2)
  );

  assign rs1_addr  = in_inst[19:15];
  assign rs2_addr  = in_inst[24:20];
  assign csr_addr  = in_inst[31:20];
  assign in_ready  = (count_q != CNTW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;
  assign count     = count_q;

  always_comb begin
    new_ent.dec      = dec;
    new_ent.rs1_data = use_rs1 ? rs1_data : '0;
    new_ent.rs2_data = use_rs2 ? rs2_data : '0;
    new_ent.csr_data = csr_data;
    new_ent.pc       = in_pc;
    new_ent.inst     = in_inst;
    new_ent.is_pre   = in_is_pre;
  end

  always_comb begin
    ent_d    = ent_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        ent_d[wr_ptr_q] = new_ent;
        wr_ptr_d        = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNTW'(1);
        2'b01:   count_d = count_q - CNTW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload needs no reset: it is only visible through the out_valid gate below.
  always_ff @(posedge clock) begin
    ent_q <= ent_d;
  end

  always_comb begin
    head = out_valid ? ent_q[rd_ptr_q] : '0;
  end

  assign out_opType      = head.dec.op_type;
  assign out_exuType     = head.dec.exu_type;
  assign out_imm         = head.dec.imm;
  assign out_rs1_addr    = head.dec.rs1_addr;
  assign out_rs2_addr    = head.dec.rs2_addr;
  assign out_dest_addr   = head.dec.dest_addr;
  assign out_dest_is_reg = head.dec.dest_is_reg;
  assign out_illegal     = head.dec.illegal;
  assign out_rs1_data    = head.rs1_data;
  assign out_rs2_data    = head.rs2_data;
  assign out_csr_data    = head.csr_data;
  assign out_pc          = head.pc;
  assign out_inst        = head.inst;
  assign out_csr_addr    = head.inst[31:20];
  assign out_is_pre      = head.is_pre;

endmodule

// File: tb/tb_decode_buf.sv
// Directed self-checking bench for decode_buf (XLEN=64, DEPTH=2).
module tb_decode_buf;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CNTW  = $clog2(DEPTH) + 1;

  localparam logic [31:0] InstAddi = 32'hFFF08293;
  localparam logic [31:0] InstNop  = 32'h00000013;
  localparam logic [31:0] InstJal  = 32'h008000EF;
  localparam logic [31:0] InstSd   = 32'h0020B423;
  localparam logic [31:0] InstMul  = 32'h022081B3;

  logic            clock, reset;
  logic            in_valid, in_ready, in_is_pre;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc, rs1_data, rs2_data, csr_data;
  logic [4:0]      rs1_addr, rs2_addr;
  logic [11:0]     csr_addr;
  logic            out_valid, out_ready;
  logic [2:0]      out_opType;
  logic [6:0]      out_exuType;
  logic [31:0]     out_imm, out_inst;
  logic [4:0]      out_rs1_addr, out_rs2_addr, out_dest_addr;
  logic [XLEN-1:0] out_rs1_data, out_rs2_data, out_csr_data, out_pc;
  logic [11:0]     out_csr_addr;
  logic            out_dest_is_reg, out_is_pre, out_illegal;
  logic [CNTW-1:0] count;
  logic            flush;

  int n_chk  = 0;
  int n_fail = 0;

  decode_buf #(.XLEN(XLEN), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .in_is_pre(in_is_pre),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .csr_addr(csr_addr), .csr_data(csr_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_opType(out_opType), .out_exuType(out_exuType), .out_imm(out_imm),
    .out_rs1_addr(out_rs1_addr), .out_rs2_addr(out_rs2_addr), .out_dest_addr(out_dest_addr),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_csr_data(out_csr_data),
    .out_pc(out_pc), .out_inst(out_inst), .out_csr_addr(out_csr_addr),
    .out_dest_is_reg(out_dest_is_reg), .out_is_pre(out_is_pre), .out_illegal(out_illegal),
    .count(count), .flush(flush)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push_one(input logic [31:0] inst, input logic [XLEN-1:0] pc,
                          input logic [XLEN-1:0] r1, input logic [XLEN-1:0] r2);
    in_valid = 1'b1; in_inst = inst; in_pc = pc; rs1_data = r1; rs2_data = r2;
    step();
    in_valid = 1'b0;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    n_chk++; if (count !== 2'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    n_chk++; if (out_inst !== 32'h0) begin n_fail++; $display("FAIL reset_out_inst got %h exp 0", out_inst); end
  endtask

  task automatic test_addi();
    in_inst = InstAddi; csr_data = 64'h99; in_is_pre = 1'b1;
    #1;
    n_chk++; if (rs1_addr !== 5'd1) begin n_fail++; $display("FAIL port_rs1_addr got %0d exp 1", rs1_addr); end
    n_chk++; if (rs2_addr !== 5'd31) begin n_fail++; $display("FAIL port_rs2_addr got %0d exp 31", rs2_addr); end
    n_chk++; if (csr_addr !== 12'hFFF) begin n_fail++; $display("FAIL port_csr_addr got %h exp fff", csr_addr); end
    push_one(InstAddi, 64'h100, 64'd7, 64'h55);
    in_is_pre = 1'b0;
    n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL addi_valid got %b exp 1", out_valid); end
    n_chk++; if (out_opType !== 3'd1) begin n_fail++; $display("FAIL addi_op got %0d exp 1", out_opType); end
    n_chk++; if (out_exuType !== 7'h00) begin n_fail++; $display("FAIL addi_exu got %h exp 00", out_exuType); end
    n_chk++; if (out_imm !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL addi_imm got %h exp ffffffff", out_imm); end
    n_chk++; if (out_rs1_addr !== 5'd1) begin n_fail++; $display("FAIL addi_rs1 got %0d exp 1", out_rs1_addr); end
    n_chk++; if (out_rs1_data !== 64'd7) begin n_fail++; $display("FAIL addi_rs1_data got %h exp 7", out_rs1_data); end
    n_chk++; if (out_rs2_addr !== 5'd0) begin n_fail++; $display("FAIL addi_rs2 got %0d exp 0", out_rs2_addr); end
    n_chk++; if (out_rs2_data !== 64'd0) begin n_fail++; $display("FAIL addi_rs2_data got %h exp 0", out_rs2_data); end
    n_chk++; if (out_dest_addr !== 5'd5) begin n_fail++; $display("FAIL addi_dest got %0d exp 5", out_dest_addr); end
    n_chk++; if (out_dest_is_reg !== 1'b1) begin n_fail++; $display("FAIL addi_dest_is_reg got %b exp 1", out_dest_is_reg); end
    n_chk++; if (out_pc !== 64'h100) begin n_fail++; $display("FAIL addi_pc got %h exp 100", out_pc); end
    n_chk++; if (out_csr_data !== 64'h99) begin n_fail++; $display("FAIL addi_csr_data got %h exp 99", out_csr_data); end
    n_chk++; if (out_csr_addr !== 12'hFFF) begin n_fail++; $display("FAIL addi_csr_addr got %h exp fff", out_csr_addr); end
    n_chk++; if (out_is_pre !== 1'b1) begin n_fail++; $display("FAIL addi_is_pre got %b exp 1", out_is_pre); end
    n_chk++; if (out_illegal !== 1'b0) begin n_fail++; $display("FAIL addi_illegal got %b exp 0", out_illegal); end
    pop_one();
    n_chk++; if (count !== 2'd0) begin n_fail++; $display("FAIL addi_pop_count got %0d exp 0", count); end
  endtask

  task automatic test_jal();
    push_one(InstJal, 64'h200, 64'hDEAD, 64'hBEEF);
    n_chk++; if (out_opType !== 3'd2) begin n_fail++; $display("FAIL jal_op got %0d exp 2", out_opType); end
    n_chk++; if (out_exuType !== 7'h4E) begin n_fail++; $display("FAIL jal_exu got %h exp 4e", out_exuType); end
    n_chk++; if (out_imm !== 32'd8) begin n_fail++; $display("FAIL jal_imm got %h exp 8", out_imm); end
    n_chk++; if (out_rs1_addr !== 5'd0) begin n_fail++; $display("FAIL jal_rs1 got %0d exp 0", out_rs1_addr); end
    n_chk++; if (out_rs1_data !== 64'd0) begin n_fail++; $display("FAIL jal_rs1_data got %h exp 0", out_rs1_data); end
    n_chk++; if (out_dest_addr !== 5'd1) begin n_fail++; $display("FAIL jal_dest got %0d exp 1", out_dest_addr); end
    n_chk++; if (out_dest_is_reg !== 1'b1) begin n_fail++; $display("FAIL jal_dest_is_reg got %b exp 1", out_dest_is_reg); end
    pop_one();
  endtask

  task automatic test_store_mul();
    push_one(InstSd, 64'h300, 64'h11, 64'h22);
    n_chk++; if (out_opType !== 3'd0) begin n_fail++; $display("FAIL sd_op got %0d exp 0", out_opType); end
    n_chk++; if (out_exuType !== 7'h0E) begin n_fail++; $display("FAIL sd_exu got %h exp 0e", out_exuType); end
    n_chk++; if (out_imm !== 32'd8) begin n_fail++; $display("FAIL sd_imm got %h exp 8", out_imm); end
    n_chk++; if (out_rs2_addr !== 5'd2) begin n_fail++; $display("FAIL sd_rs2 got %0d exp 2", out_rs2_addr); end
    n_chk++; if (out_rs2_data !== 64'h22) begin n_fail++; $display("FAIL sd_rs2_data got %h exp 22", out_rs2_data); end
    n_chk++; if (out_dest_is_reg !== 1'b0) begin n_fail++; $display("FAIL sd_dest_is_reg got %b exp 0", out_dest_is_reg); end
    pop_one();
    push_one(InstMul, 64'h304, 64'h3, 64'h4);
    n_chk++; if (out_opType !== 3'd5) begin n_fail++; $display("FAIL mul_op got %0d exp 5", out_opType); end
    n_chk++; if (out_exuType !== 7'h02) begin n_fail++; $display("FAIL mul_exu got %h exp 02", out_exuType); end
    n_chk++; if (out_imm !== 32'd0) begin n_fail++; $display("FAIL mul_imm got %h exp 0", out_imm); end
    n_chk++; if (out_dest_addr !== 5'd3) begin n_fail++; $display("FAIL mul_dest got %0d exp 3", out_dest_addr); end
    pop_one();
  endtask

  task automatic test_illegal();
    push_one(32'h0000_0000, 64'h400, 64'h1, 64'h2);
    n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ill_valid got %b exp 1", out_valid); end
    n_chk++; if (out_illegal !== 1'b1) begin n_fail++; $display("FAIL ill_flag got %b exp 1", out_illegal); end
    n_chk++; if (out_opType !== 3'd3) begin n_fail++; $display("FAIL ill_op got %0d exp 3", out_opType); end
    n_chk++; if (out_exuType !== 7'h00) begin n_fail++; $display("FAIL ill_exu got %h exp 00", out_exuType); end
    n_chk++; if (out_dest_is_reg !== 1'b0) begin n_fail++; $display("FAIL ill_dest_is_reg got %b exp 0", out_dest_is_reg); end
    pop_one();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0; in_valid = 1'b1; in_inst = InstNop;
    in_pc = 64'h10; step();
    n_chk++; if (count !== 2'd1) begin n_fail++; $display("FAIL b2b_count1 got %0d exp 1", count); end
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready1 got %b exp 1", in_ready); end
    in_pc = 64'h14; step();
    n_chk++; if (count !== 2'd2) begin n_fail++; $display("FAIL b2b_count2 got %0d exp 2", count); end
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full_ready got %b exp 0", in_ready); end
    in_pc = 64'h18; step();
    n_chk++; if (count !== 2'd2) begin n_fail++; $display("FAIL b2b_third_count got %0d exp 2", count); end
    n_chk++; if (out_pc !== 64'h10) begin n_fail++; $display("FAIL b2b_head_a got %h exp 10", out_pc); end
    out_ready = 1'b1; #1;
    n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_no_comb_ready got %b exp 0", in_ready); end
    step();
    n_chk++; if (count !== 2'd1) begin n_fail++; $display("FAIL b2b_pop_a_count got %0d exp 1", count); end
    n_chk++; if (out_pc !== 64'h14) begin n_fail++; $display("FAIL b2b_head_b got %h exp 14", out_pc); end
    step();
    n_chk++; if (count !== 2'd1) begin n_fail++; $display("FAIL b2b_pushpop_count got %0d exp 1", count); end
    n_chk++; if (out_pc !== 64'h18) begin n_fail++; $display("FAIL b2b_head_c got %h exp 18", out_pc); end
    in_valid = 1'b0; step();
    out_ready = 1'b0;
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drained got %b exp 0", out_valid); end
  endtask

  task automatic test_stream();
    out_ready = 1'b1; in_valid = 1'b1; in_inst = InstNop;
    for (int i = 0; i < 5; i++) begin
      in_pc = 64'h500 + 64'(4 * i);
      step();
      n_chk++; if (count !== 2'd1) begin n_fail++; $display("FAIL stream_count[%0d] got %0d exp 1", i, count); end
      n_chk++; if (out_pc !== 64'h500 + 64'(4 * i)) begin n_fail++; $display("FAIL stream_pc[%0d] got %h exp %h", i, out_pc, 64'h500 + 64'(4 * i)); end
    end
    in_valid = 1'b0; step();
    out_ready = 1'b0;
    n_chk++; if (count !== 2'd0) begin n_fail++; $display("FAIL stream_end_count got %0d exp 0", count); end
  endtask

  task automatic test_flush();
    push_one(InstNop, 64'h30, 64'h0, 64'h0);
    push_one(InstNop, 64'h34, 64'h0, 64'h0);
    in_valid = 1'b1; in_pc = 64'h38; flush = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    n_chk++; if (count !== 2'd0) begin n_fail++; $display("FAIL flush_count got %0d exp 0", count); end
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid got %b exp 0", out_valid); end
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready got %b exp 1", in_ready); end
    n_chk++; if (out_pc !== 64'h0) begin n_fail++; $display("FAIL flush_pc got %h exp 0", out_pc); end
    push_one(InstNop, 64'h3C, 64'h0, 64'h0);
    n_chk++; if (out_pc !== 64'h3C) begin n_fail++; $display("FAIL flush_after_pc got %h exp 3c", out_pc); end
    n_chk++; if (count !== 2'd1) begin n_fail++; $display("FAIL flush_after_count got %0d exp 1", count); end
    pop_one();
  endtask

  task automatic test_reset_mid();
    push_one(InstAddi, 64'h60, 64'h7, 64'h0);
    push_one(InstJal, 64'h64, 64'h0, 64'h0);
    in_valid = 1'b1; in_pc = 64'h68; reset = 1'b1;
    step();
    in_valid = 1'b0; reset = 1'b0;
    n_chk++; if (count !== 2'd0) begin n_fail++; $display("FAIL rstmid_count got %0d exp 0", count); end
    n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid got %b exp 0", out_valid); end
    n_chk++; if (out_inst !== 32'h0) begin n_fail++; $display("FAIL rstmid_inst got %h exp 0", out_inst); end
    n_chk++; if (out_imm !== 32'h0) begin n_fail++; $display("FAIL rstmid_imm got %h exp 0", out_imm); end
    n_chk++; if (out_opType !== 3'd0) begin n_fail++; $display("FAIL rstmid_op got %0d exp 0", out_opType); end
    n_chk++; if (out_rs1_data !== 64'h0) begin n_fail++; $display("FAIL rstmid_rs1_data got %h exp 0", out_rs1_data); end
    n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready got %b exp 1", in_ready); end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_inst = '0; in_pc = '0; in_is_pre = 1'b0;
    rs1_data = '0; rs2_data = '0; csr_data = '0; out_ready = 1'b0; flush = 1'b0;
    test_reset();
    test_addi();
    test_jal();
    test_store_mul();
    test_illegal();
    test_back_to_back();
    test_stream();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
